// File: rtl/dcache_2way.sv
// 2-way set-associative write-back, write-allocate data cache with 32-byte lines and per-set LRU.
// Define DCACHE_PERF_CNT_EN to build the hit/miss performance counters; otherwise they read as 0.
module dcache_2way_top #(
  parameter int INDEX_W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [255:0] mem_data_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [31:0]  p1_data_i,
  input  logic [31:0]  p1_addr_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o,
  output logic [1:0]   dbg_state_o
);

  localparam int TAG_W = 27 - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WRITEBACK  = 2'd1;
  localparam logic [1:0] REFILL     = 2'd2;
  localparam logic [1:0] REFILLDONE = 2'd3;

  logic [255:0]       data0 [SETS];
  logic [255:0]       data1 [SETS];
  logic [TAG_W-1:0]   tag0  [SETS];
  logic [TAG_W-1:0]   tag1  [SETS];
  logic [SETS-1:0]    valid0, valid1, dirty0, dirty1, lru;

  logic [1:0]         state_q;
  logic               vic_way_q;
  logic [INDEX_W-1:0] vic_idx_q;
  logic [TAG_W-1:0]   miss_tag_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [2:0]         woff;
  logic               req, hit_w0, hit_w1, hit;
  logic               accept_hit, store_we, miss_start, refill_we;
  logic               vic_way, vic_dirty;
  logic [TAG_W-1:0]   wb_tag;
  logic               unused_addr_bits;

  assign idx  = p1_addr_i[4+INDEX_W:5];
  assign tag  = p1_addr_i[31:5+INDEX_W];
  assign woff = p1_addr_i[4:2];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign req    = p1_MemRead_i | p1_MemWrite_i;
  assign hit_w0 = valid0[idx] & (tag0[idx] == tag);
  assign hit_w1 = valid1[idx] & (tag1[idx] == tag);
  assign hit    = hit_w0 | hit_w1;

  // A hit is only serviced in IDLE or REFILLDONE; while a miss is in flight the CPU stays stalled.
  assign accept_hit = req & hit & ((state_q == IDLE) | (state_q == REFILLDONE));
  assign store_we   = accept_hit & p1_MemWrite_i;
  assign miss_start = (state_q == IDLE) & req & ~hit;
  assign refill_we  = (state_q == REFILL) & mem_ack_i;

  assign p1_stall_o  = req & ~accept_hit;
  assign dbg_state_o = state_q;

  always_comb begin
    vic_way = 1'b0;
    if (!valid0[idx])      vic_way = 1'b0;
    else if (!valid1[idx]) vic_way = 1'b1;
    else                   vic_way = lru[idx];
    vic_dirty = vic_way ? (valid1[idx] & dirty1[idx]) : (valid0[idx] & dirty0[idx]);
  end

  always_comb begin
    p1_data_o = 32'd0;
    if (hit_w0)      p1_data_o = data0[idx][{woff, 5'd0} +: 32];
    else if (hit_w1) p1_data_o = data1[idx][{woff, 5'd0} +: 32];
  end

  // Memory handshake: mem_enable_o stays high with address/data stable until a one-cycle
  // mem_ack_i; WRITEBACK addresses the victim line, REFILL the missing line.
  assign wb_tag     = vic_way_q ? tag1[vic_idx_q] : tag0[vic_idx_q];
  assign mem_data_o = vic_way_q ? data1[vic_idx_q] : data0[vic_idx_q];

  always_comb begin
    mem_addr_o = {miss_tag_q, vic_idx_q, 5'd0};
    if (state_q == WRITEBACK) mem_addr_o = {wb_tag, vic_idx_q, 5'd0};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      valid0       <= '0;
      valid1       <= '0;
      dirty0       <= '0;
      dirty1       <= '0;
      lru          <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      vic_way_q    <= 1'b0;
      vic_idx_q    <= '0;
      miss_tag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            vic_way_q    <= vic_way;
            vic_idx_q    <= idx;
            miss_tag_q   <= tag;
            mem_enable_o <= 1'b1;
            mem_write_o  <= vic_dirty;
            state_q      <= vic_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            mem_write_o <= 1'b0;
            state_q     <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            state_q      <= REFILLDONE;
            if (vic_way_q) begin
              valid1[vic_idx_q] <= 1'b1;
              dirty1[vic_idx_q] <= 1'b0;
            end else begin
              valid0[vic_idx_q] <= 1'b1;
              dirty0[vic_idx_q] <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // LRU points at the way not just used, i.e. the next victim.
      if (accept_hit) begin
        lru[idx] <= hit_w0;
        if (store_we) begin
          if (hit_w0) dirty0[idx] <= 1'b1;
          else        dirty1[idx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (refill_we) begin
      if (vic_way_q) begin
        data1[vic_idx_q] <= mem_data_i;
        tag1[vic_idx_q]  <= miss_tag_q;
      end else begin
        data0[vic_idx_q] <= mem_data_i;
        tag0[vic_idx_q]  <= miss_tag_q;
      end
    end else if (store_we) begin
      if (hit_w0) data0[idx][{woff, 5'd0} +: 32] <= p1_data_i;
      else        data1[idx][{woff, 5'd0} +: 32] <= p1_data_i;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if ((state_q == IDLE) && req && hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = 32'd0;
  assign miss_cnt_o = 32'd0;
`endif

endmodule
